// File: rtl/dma_pkg.sv
// Types and constants shared by the DMA RAM and the DMA controller.
package dma_pkg;

    localparam int WS_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RDY  = 2'd2
    } dma_state_t;

endpackage

// File: rtl/ram_core.sv
// Word storage: one synchronous write port and one registered read port.
// Contents power up as mem[i] = i and are never touched by reset.
module ram_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word = DATA_W'(i);

        always_ff @(posedge clk) begin
            if (we && waddr == IDX_W'(i)) begin
                word <= wdata;
            end
        end

        assign words[i] = word;
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= words[raddr];
        end
    end

endmodule

// File: rtl/dma_ram.sv
// Dual-access RAM: a DMA handshake port (MEMW/MEMR with READY/ack) and a
// processor direct port (MEMWP/MEMRP) sharing one address and data bus.
module dma_ram
    import dma_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEMW,
    input  logic              MEMR,
    input  logic              READY_IO,
    input  logic              MEM_TO_MEM,
    input  logic              MEMWP,
    input  logic              MEMRP,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              READY,
    output logic              ERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WS_W-1:0]   WS_LOAD   = WS_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dma_state_t        state, state_next;
    logic [WS_W-1:0]   count, count_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic              write_q, write_next;
    logic              bad_q, bad_next;
    logic              hs_drive;
    logic              rp_valid;

    logic              req, ack, addr_bad, direct_ok, direct_wr, direct_rd, err_next;
    logic              we, re;
    logic [IDX_W-1:0]  waddr, raddr;
    logic [DATA_W-1:0] rdata;

    assign req       = MEMW | MEMR;
    assign ack       = READY_IO | MEM_TO_MEM;
    assign addr_bad  = address > LAST_ADDR;
    // The direct port only gets the memory when the handshake side is quiet.
    assign direct_ok = (state == IDLE) && !req;
    assign direct_wr = direct_ok && MEMWP && !addr_bad;
    assign direct_rd = direct_ok && MEMRP && !MEMWP && !addr_bad;
    assign err_next  = ((state == IDLE) && req && addr_bad)
                     || ((MEMWP || MEMRP) && (!direct_ok || addr_bad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            bad_q    <= 1'b0;
            READY    <= 1'b0;
            ERR      <= 1'b0;
            hs_drive <= 1'b0;
            rp_valid <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            addr_q   <= addr_next;
            write_q  <= write_next;
            bad_q    <= bad_next;
            READY    <= (state_next == RDY);
            ERR      <= err_next;
            hs_drive <= (state_next == RDY) && !write_next;
            rp_valid <= direct_rd;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        addr_next  = addr_q;
        write_next = write_q;
        bad_next   = bad_q;
        we         = 1'b0;
        re         = 1'b0;
        waddr      = IDX_W'(address);
        raddr      = IDX_W'(address);

        case (state)
            IDLE: begin
                if (req) begin
                    addr_next  = address;
                    write_next = MEMW;
                    bad_next   = addr_bad;
                    if (WAIT_STATES == 0) begin
                        state_next = RDY;
                        re         = !MEMW && !addr_bad;
                    end else begin
                        state_next = WAIT;
                        count_next = WS_LOAD;
                    end
                end else begin
                    we = direct_wr;
                    re = direct_rd;
                end
            end
            WAIT: begin
                if (count == '0) begin
                    state_next = RDY;
                    re         = !write_q && !bad_q;
                    raddr      = IDX_W'(addr_q);
                end else begin
                    count_next = count - 1'b1;
                end
            end
            RDY: begin
                // Only an acknowledge ends the access; dropping MEMW/MEMR does not.
                if (ack) begin
                    state_next = IDLE;
                    we         = write_q && !bad_q;
                    waddr      = IDX_W'(addr_q);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (data),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    // Out-of-range handshake reads still complete but return zeros.
    assign data = (hs_drive || rp_valid) ? ((hs_drive && bad_q) ? '0 : rdata)
                                         : {DATA_W{1'bz}};

endmodule

// File: tb/tb_dma_ram.sv
// Directed scoreboard bench for dma_ram: DUT A (8-bit, 16 words, 3 wait states)
// and DUT B (16-bit, 64 words, no wait states).
module tb_dma_ram;

    localparam logic [7:0]  PROBE_A = 8'h3C;
    localparam logic [15:0] PROBE_B = 16'hC3C3;

    logic clk = 1'b0;
    logic rst_n;

    logic        memw_a, memr_a, rio_a, m2m_a, wp_a, rp_a, drv_a;
    logic [15:0] addr_a;
    logic [7:0]  dout_a;
    wire  [7:0]  data_a;
    logic        ready_a, err_a;

    logic        memw_b, memr_b, rio_b, m2m_b, wp_b, rp_b, drv_b;
    logic [15:0] addr_b;
    logic [15:0] dout_b;
    wire  [15:0] data_b;
    logic        ready_b, err_b;

    typedef struct {
        string       tag;
        logic [15:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem_a [16];
    logic [15:0] mem_b [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n;

    assign data_a = drv_a ? dout_a : 8'hzz;
    assign data_b = drv_b ? dout_b : 16'hzzzz;

    always #5 clk = ~clk;

    dma_ram #(
        .DATA_W(8), .ADDR_W(16), .DEPTH(16), .WAIT_STATES(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .MEMW(memw_a), .MEMR(memr_a),
        .READY_IO(rio_a), .MEM_TO_MEM(m2m_a), .MEMWP(wp_a), .MEMRP(rp_a),
        .address(addr_a), .data(data_a), .READY(ready_a), .ERR(err_a)
    );

    dma_ram #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(64), .WAIT_STATES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .MEMW(memw_b), .MEMR(memr_b),
        .READY_IO(rio_b), .MEM_TO_MEM(m2m_b), .MEMWP(wp_b), .MEMRP(rp_b),
        .address(addr_b), .data(data_b), .READY(ready_b), .ERR(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_read(input string tag, input logic [15:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input logic [15:0] obs);
        exp_t e;
        check_output("scoreboard not empty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output(e.tag, 32'(obs), 32'(e.value));
        end
    endtask

    // Steps until the selected READY is high; gives up after 20 cycles.
    task automatic wait_ready(input int d, output int cycles);
        cycles = 0;
        while (((d == 0) ? ready_a : ready_b) == 1'b0 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 64; i++) mem_b[i] = 16'(i);
        rst_n  = 1'b0;
        {memw_a, memr_a, rio_a, m2m_a, wp_a, rp_a} = '0;
        {memw_b, memr_b, rio_b, m2m_b, wp_b, rp_b} = '0;
        addr_a = '0; addr_b = '0;
        drv_a  = 1'b1; dout_a = PROBE_A;
        drv_b  = 1'b1; dout_b = PROBE_B;

        tick();
        tick();
        check_output("reset ready_a", 32'(ready_a), 32'd0);
        check_output("reset err_a", 32'(err_a), 32'd0);
        check_output("reset bus_a released", 32'(data_a), 32'(PROBE_A));
        check_output("reset ready_b", 32'(ready_b), 32'd0);
        check_output("reset err_b", 32'(err_b), 32'd0);
        check_output("reset bus_b released", 32'(data_b), 32'(PROBE_B));
        rst_n = 1'b1;
        tick();

        // B, no wait states: handshake read of word 5.
        memr_b = 1'b1; addr_b = 16'd5; drv_b = 1'b0;
        expect_read("b hs read 5", mem_b[5]);
        tick();
        check_output("b ws0 ready after 1 cycle", 32'(ready_b), 32'd1);
        pop_compare(data_b);
        memr_b = 1'b0;
        tick();
        check_output("b ready holds without ack", 32'(ready_b), 32'd1);
        check_output("b data holds without ack", 32'(data_b), 32'd5);
        rio_b = 1'b1; drv_b = 1'b1; dout_b = PROBE_B;
        tick();
        check_output("b ready falls on ack", 32'(ready_b), 32'd0);
        check_output("b bus released after ack", 32'(data_b), 32'(PROBE_B));
        rio_b = 1'b0;

        // B, out-of-range direct write is ignored and flagged.
        wp_b = 1'b1; addr_b = 16'd64; dout_b = 16'hDEAD;
        tick();
        check_output("b direct oob err", 32'(err_b), 32'd1);
        wp_b = 1'b0;
        tick();
        check_output("b err single pulse", 32'(err_b), 32'd0);
        rp_b = 1'b1; addr_b = 16'd0; drv_b = 1'b0;
        expect_read("b word 0 not aliased", mem_b[0]);
        tick();
        pop_compare(data_b);
        rp_b = 1'b0;

        // B, MEMWP and MEMRP together: write only, no read return.
        wp_b = 1'b1; rp_b = 1'b1; addr_b = 16'd10; drv_b = 1'b1; dout_b = 16'h1234;
        tick();
        check_output("b wp+rp no err", 32'(err_b), 32'd0);
        check_output("b wp+rp no read return", 32'(data_b), 32'h1234);
        mem_b[10] = 16'h1234;
        wp_b = 1'b0;
        drv_b = 1'b0;
        expect_read("b direct readback 10", mem_b[10]);
        tick();
        pop_compare(data_b);
        rp_b = 1'b0; drv_b = 1'b1; dout_b = PROBE_B;

        // A, three wait states: handshake write then direct readback.
        memw_a = 1'b1; addr_a = 16'd2; drv_a = 1'b1; dout_a = 8'hA5;
        tick();
        memw_a = 1'b0;
        wait_ready(0, n);
        check_output("a ws3 write ready latency", 32'(n), 32'd3);
        tick();
        check_output("a ready holds in RDY", 32'(ready_a), 32'd1);
        m2m_a = 1'b1;
        tick();
        check_output("a ready falls on mem_to_mem", 32'(ready_a), 32'd0);
        mem_a[2] = 8'hA5;
        m2m_a = 1'b0;
        rp_a = 1'b1; addr_a = 16'd2; drv_a = 1'b0;
        expect_read("a direct read 2", 16'(mem_a[2]));
        tick();
        pop_compare(16'(data_a));
        rp_a = 1'b0; drv_a = 1'b1; dout_a = PROBE_A;
        tick();
        check_output("a direct return lasts one cycle", 32'(data_a), 32'(PROBE_A));

        // A, out-of-range handshake read.
        memr_a = 1'b1; addr_a = 16'd20; drv_a = 1'b0;
        expect_read("a oob read zero", 16'h0000);
        tick();
        check_output("a oob accept err", 32'(err_a), 32'd1);
        memr_a = 1'b0;
        tick();
        check_output("a oob err single pulse", 32'(err_a), 32'd0);
        wait_ready(0, n);
        check_output("a oob ready latency", 32'(n), 32'd2);
        pop_compare(16'(data_a));
        rio_a = 1'b1; drv_a = 1'b1; dout_a = PROBE_A;
        tick();
        check_output("a oob ready falls", 32'(ready_a), 32'd0);
        rio_a = 1'b0;
        rp_a = 1'b1; addr_a = 16'd4; drv_a = 1'b0;
        expect_read("a word 4 unchanged", 16'(mem_a[4]));
        tick();
        pop_compare(16'(data_a));
        rp_a = 1'b0; drv_a = 1'b1;

        // A, direct write while the FSM is busy is refused.
        memr_a = 1'b1; addr_a = 16'd9; drv_a = 1'b0;
        expect_read("a hs read 9", 16'(mem_a[9]));
        tick();
        memr_a = 1'b0;
        wp_a = 1'b1; addr_a = 16'd3; drv_a = 1'b1; dout_a = 8'h77;
        tick();
        check_output("a busy direct write err", 32'(err_a), 32'd1);
        wp_a = 1'b0; drv_a = 1'b0;
        wait_ready(0, n);
        check_output("a read latency with busy wp", 32'(n), 32'd2);
        pop_compare(16'(data_a));
        rio_a = 1'b1; drv_a = 1'b1; dout_a = PROBE_A;
        tick();
        rio_a = 1'b0;
        rp_a = 1'b1; addr_a = 16'd3; drv_a = 1'b0;
        expect_read("a word 3 not written", 16'(mem_a[3]));
        tick();
        pop_compare(16'(data_a));
        rp_a = 1'b0; drv_a = 1'b1;

        // A, reset while a write sits in RDY.
        memw_a = 1'b1; addr_a = 16'd6; dout_a = 8'hC3;
        tick();
        memw_a = 1'b0;
        wait_ready(0, n);
        check_output("a write reaches RDY", 32'(ready_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("a ready cleared by reset", 32'(ready_a), 32'd0);
        check_output("a bus released by reset", 32'(data_a), 32'hC3);
        tick();
        rst_n = 1'b1;
        memr_a = 1'b1; addr_a = 16'd6; drv_a = 1'b0;
        expect_read("a word 6 survives reset", 16'(mem_a[6]));
        tick();
        memr_a = 1'b0;
        wait_ready(0, n);
        check_output("a read after reset latency", 32'(n), 32'd3);
        pop_compare(16'(data_a));
        rio_a = 1'b1; drv_a = 1'b1; dout_a = PROBE_A;
        tick();
        rio_a = 1'b0;

        // B, back-to-back handshake writes over the whole array.
        memw_b = 1'b1; drv_b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            addr_b = 16'(i);
            dout_b = 16'(i * 257) ^ 16'h5A3C;
            tick();
            check_output($sformatf("b b2b accept %0d", i), 32'(ready_b), 32'd1);
            rio_b = 1'b1;
            tick();
            check_output($sformatf("b b2b idle gap %0d", i), 32'(ready_b), 32'd0);
            mem_b[i] = dout_b;
            rio_b = 1'b0;
        end
        memw_b = 1'b0;

        rp_b = 1'b1; drv_b = 1'b0;
        for (int i = 0; i < 64; i++) begin
            addr_b = 16'(i);
            expect_read($sformatf("b readback %0d", i), mem_b[i]);
            tick();
            pop_compare(data_b);
        end
        rp_b = 1'b0; drv_b = 1'b1; dout_b = PROBE_B;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
